test_result_monitor: RTL and testbench

- Synthesizable, parametrised pass/fail monitor for CPU regression runs.
- Snoops the memory write bus and captures the last byte written to up to NUM_CHECKS result addresses.
- Ends a run on a write to a sentinel address or on a cycle timeout, then checks the captured bytes against the expected values.
- Sits beside the memory block in the test harness and replaces fixed-delay single-address result checks with a multi-address, timed, self-reporting check.

---
 rtl/test_result_monitor.sv | 168 ++++++++++++++++
 tb/tb_test_result_monitor.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_result_monitor.sv
// Regression pass/fail monitor: snoops memory writes into per-channel result registers,
// ends on a DONE_ADDR write or a timeout, then scans the channels one per cycle.
// Optional build macro MON_TRACE_EN adds bad_data reporting and per-channel write counters.
module test_result_monitor #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter int                    NUM_CHECKS     = 4,
  parameter logic [ADDR_WIDTH-1:0] DONE_ADDR      = 16'h00FF,
  parameter int                    TIMEOUT_CYCLES = 120,
  parameter int                    CYC_WIDTH      = 16,
  parameter int                    IDX_W          = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                             ph2,
  input  logic                             resetb,
  input  logic                             start,
  input  logic                             mem_we,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [7:0]                       wdata,
  input  logic [NUM_CHECKS-1:0]            chk_en,
  input  logic [NUM_CHECKS*ADDR_WIDTH-1:0] chk_addr,
  input  logic [NUM_CHECKS*8-1:0]          chk_data,
  output logic                             done,
  output logic                             pass,
  output logic                             fail,
  output logic                             timeout,
  output logic [IDX_W-1:0]                 fail_idx,
  output logic [CYC_WIDTH-1:0]             cycles,
  output logic [7:0]                       bad_data
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [NUM_CHECKS-1:0]   seen_q;
  logic [7:0]              cap_q [NUM_CHECKS];
  logic [CYC_WIDTH-1:0]    cycles_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        fail_idx_q;
  logic                    found_q;
  logic                    timeout_q;
  logic                    pass_q;
  logic                    fail_q;

  logic                    done_hit;
  logic                    arm;
  logic                    run_timeout;
  logic                    chk_last;
  logic                    chan_fail;
  logic [NUM_CHECKS-1:0]   hit;

  assign done_hit    = mem_we && (addr == DONE_ADDR);
  assign arm         = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  // A DONE_ADDR write on the last allowed cycle takes priority over the timeout.
  assign run_timeout = !done_hit && (cycles_q == CYC_WIDTH'(TIMEOUT_CYCLES - 1));
  assign chk_last    = (idx_q == IDX_W'(NUM_CHECKS - 1));
  assign chan_fail   = chk_en[idx_q] &&
                       (!seen_q[idx_q] || (cap_q[idx_q] != chk_data[idx_q*8 +: 8]));

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      hit[i] = mem_we && chk_en[i] && (addr == chk_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (done_hit || run_timeout) state_d = S_CHECK;
      S_CHECK: if (chk_last) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      seen_q     <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) cap_q[i] <= '0;
      cycles_q   <= '0;
      idx_q      <= '0;
      fail_idx_q <= '0;
      found_q    <= 1'b0;
      timeout_q  <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            seen_q     <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) cap_q[i] <= '0;
            cycles_q   <= '0;
            idx_q      <= '0;
            fail_idx_q <= '0;
            found_q    <= 1'b0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (cycles_q != '1) cycles_q <= cycles_q + 1'b1;
          for (int i = 0; i < NUM_CHECKS; i++) begin
            if (hit[i]) begin
              cap_q[i]  <= wdata;
              seen_q[i] <= 1'b1;
            end
          end
          if (run_timeout) timeout_q <= 1'b1;
        end
        S_CHECK: begin
          if (chan_fail && !found_q) begin
            found_q    <= 1'b1;
            fail_idx_q <= idx_q;
          end
          if (chk_last) begin
            pass_q <= !(found_q || chan_fail) && !timeout_q;
            fail_q <= found_q || chan_fail || timeout_q;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MON_TRACE_EN
  logic [7:0] bad_q;
  logic [7:0] wcnt_q [NUM_CHECKS];

  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      bad_q <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) wcnt_q[i] <= '0;
    end else begin
      if (arm) begin
        bad_q <= '0;
        for (int i = 0; i < NUM_CHECKS; i++) wcnt_q[i] <= '0;
      end else if (state_q == S_RUN) begin
        for (int i = 0; i < NUM_CHECKS; i++) begin
          if (hit[i] && (wcnt_q[i] != 8'hFF)) wcnt_q[i] <= wcnt_q[i] + 8'd1;
        end
      end else if ((state_q == S_CHECK) && chan_fail && !found_q) begin
        bad_q <= seen_q[idx_q] ? cap_q[idx_q] : 8'h00;
      end
    end
  end

  assign bad_data = bad_q;
`else
  assign bad_data = 8'h00;
`endif

  assign done     = (state_q == S_DONE);
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign timeout  = timeout_q;
  assign fail_idx = fail_idx_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_test_result_monitor.sv
// Bench for test_result_monitor: directed vector table, hand-written corner sequences,
// and randomized runs checked against a run-level reference model.
module tb_test_result_monitor;
  localparam int N    = 4;
  localparam int TO   = 120;
  localparam int MAXC = 128;

  logic        ph2 = 1'b0;
  logic        resetb = 1'b0;
  logic        start = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [3:0]  chk_en = '0;
  logic [63:0] chk_addr = '0;
  logic [31:0] chk_data = '0;
  logic        done, pass, fail, timeout;
  logic [1:0]  fail_idx;
  logic [15:0] cycles;
  logic [7:0]  bad_data;

  int total = 0;
  int bad = 0;

  always #5 ph2 = ~ph2;

  test_result_monitor dut (
    .ph2(ph2), .resetb(resetb), .start(start), .mem_we(mem_we), .addr(addr),
    .wdata(wdata), .chk_en(chk_en), .chk_addr(chk_addr), .chk_data(chk_data),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout), .fail_idx(fail_idx),
    .cycles(cycles), .bad_data(bad_data)
  );

  logic        we_a [MAXC];
  logic [15:0] ad_a [MAXC];
  logic [7:0]  wd_a [MAXC];
  logic        st_a [MAXC];
  logic [15:0] cha [N];
  logic [7:0]  chd [N];
  int          got_lat;

  typedef struct packed {
    logic [3:0]       en;
    logic [3:0][7:0]  d;
    logic [2:0]       nw;
    logic [3:0][15:0] wa;
    logic [3:0][7:0]  wd;
    logic             to;
    logic             ep;
    logic [1:0]       eidx;
    logic [7:0]       ebad;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < MAXC; i++) begin
      we_a[i] = 1'b0; ad_a[i] = '0; wd_a[i] = '0; st_a[i] = 1'b0;
    end
  endtask

  task automatic apply_channels(input logic [3:0] en);
    chk_en   = en;
    chk_addr = {cha[3], cha[2], cha[1], cha[0]};
    chk_data = {chd[3], chd[2], chd[1], chd[0]};
  endtask

  task automatic do_run(input int len);
    @(negedge ph2); start = 1'b1; mem_we = 1'b0;
    @(negedge ph2); start = 1'b0;
    for (int k = 0; k < len; k++) begin
      mem_we = we_a[k]; addr = ad_a[k]; wdata = wd_a[k]; start = st_a[k];
      @(negedge ph2);
    end
    mem_we = 1'b0; start = 1'b0; addr = '0;
    got_lat = 0;
    while (done !== 1'b1 && got_lat < 50) begin
      @(negedge ph2);
      got_lat++;
    end
  endtask

  task automatic check_run(input string tag, input logic ep, input logic [1:0] eidx,
                           input logic eto, input logic [7:0] ebad, input int ecyc);
    chk({tag, " latency"}, got_lat, N);
    chk({tag, " pass"}, pass, ep);
    chk({tag, " fail"}, fail, !ep);
    chk({tag, " timeout"}, timeout, eto);
    chk({tag, " fail_idx"}, fail_idx, eidx);
    chk({tag, " cycles"}, cycles, ecyc);
`ifdef MON_TRACE_EN
    chk({tag, " bad_data"}, bad_data, ebad);
`else
    chk({tag, " bad_data"}, bad_data, (ebad & 8'h00));
`endif
  endtask

  // Run-level reference: walk the write trace, keep the last byte per channel, find the end.
  task automatic model(input logic [3:0] en, output int len, output logic ep,
                       output logic [1:0] eidx, output logic eto, output logic [7:0] ebad);
    logic [7:0] last [N];
    bit         wr [N];
    bit         found;
    for (int i = 0; i < N; i++) begin last[i] = '0; wr[i] = 0; end
    len = TO; eto = 1'b0;
    for (int k = 0; k < TO; k++) begin
      for (int i = 0; i < N; i++)
        if (en[i] && we_a[k] && ad_a[k] == cha[i]) begin last[i] = wd_a[k]; wr[i] = 1; end
      if (we_a[k] && ad_a[k] == 16'h00FF) begin len = k + 1; break; end
      if (k == TO - 1) eto = 1'b1;
    end
    found = 0; eidx = '0; ebad = '0;
    for (int i = 0; i < N; i++) begin
      if (en[i] && (!wr[i] || last[i] != chd[i]) && !found) begin
        found = 1; eidx = 2'(i); ebad = wr[i] ? last[i] : 8'h00;
      end
    end
    ep = !found && !eto;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         len;
    logic       ep, eto;
    logic [1:0] eidx;
    logic [7:0] ebad;
    logic [3:0] en;
    logic [7:0] dpool [2];
    logic [15:0] apool [5];

    tbl[0] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'h1F}, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0080},
               {8'h00, 8'h00, 8'h00, 8'h1F}, 1'b0, 1'b1, 2'd0, 8'h00};
    tbl[1] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'h1F}, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0080},
               {8'h00, 8'h00, 8'h00, 8'h1E}, 1'b0, 1'b0, 2'd0, 8'h1E};
    tbl[2] = '{4'b0101, {8'h00, 8'h05, 8'h00, 8'h1F}, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0080},
               {8'h00, 8'h00, 8'h00, 8'h1F}, 1'b0, 1'b0, 2'd2, 8'h00};
    tbl[3] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'h1F}, 3'd2, {16'h0, 16'h0, 16'h0080, 16'h0080},
               {8'h00, 8'h00, 8'h1F, 8'h00}, 1'b0, 1'b1, 2'd0, 8'h00};
    tbl[4] = '{4'b0000, {8'h00, 8'h00, 8'h00, 8'h00}, 3'd0, {16'h0, 16'h0, 16'h0, 16'h0},
               {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 2'd0, 8'h00};
    tbl[5] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'h1F}, 3'd1, {16'h0, 16'h0, 16'h0, 16'h0080},
               {8'h00, 8'h00, 8'h00, 8'h1F}, 1'b1, 1'b0, 2'd0, 8'h00};
    tbl[6] = '{4'b1111, {8'h44, 8'h33, 8'h22, 8'h11}, 3'd4,
               {16'h0083, 16'h0082, 16'h0081, 16'h0080},
               {8'h45, 8'h33, 8'h22, 8'h11}, 1'b0, 1'b0, 2'd3, 8'h45};
    tbl[7] = '{4'b0010, {8'h00, 8'h00, 8'h22, 8'h00}, 3'd2, {16'h0, 16'h0, 16'h0080, 16'h0081},
               {8'h00, 8'h00, 8'h99, 8'h22}, 1'b0, 1'b1, 2'd0, 8'h00};

    // Reset state
    #12;
    chk("reset done", done, 1'b0);
    chk("reset pass", pass, 1'b0);
    chk("reset fail", fail, 1'b0);
    chk("reset cycles", cycles, 16'h0);
    @(negedge ph2); resetb = 1'b1;

    // Directed vectors: channel i sits at 0x0080+i
    for (int t = 0; t < 8; t++) begin
      clear_stim();
      for (int i = 0; i < N; i++) begin cha[i] = 16'h0080 + 16'(i); chd[i] = tbl[t].d[i]; end
      apply_channels(tbl[t].en);
      for (int w = 0; w < int'(tbl[t].nw); w++) begin
        we_a[w] = 1'b1; ad_a[w] = tbl[t].wa[w]; wd_a[w] = tbl[t].wd[w];
      end
      if (!tbl[t].to) begin
        we_a[tbl[t].nw] = 1'b1; ad_a[tbl[t].nw] = 16'h00FF; wd_a[tbl[t].nw] = 8'hA5;
      end
      len = tbl[t].to ? TO : int'(tbl[t].nw) + 1;
      do_run(len);
      check_run($sformatf("vec%0d", t), tbl[t].ep, tbl[t].eidx, tbl[t].to, tbl[t].ebad, len);
    end

    // DONE_ADDR write on the timeout cycle, with a stray start pulse mid-run
    clear_stim();
    for (int i = 0; i < N; i++) begin cha[i] = 16'h0080 + 16'(i); chd[i] = 8'h1F; end
    apply_channels(4'b0001);
    we_a[0] = 1'b1; ad_a[0] = 16'h0080; wd_a[0] = 8'h1F;
    st_a[5] = 1'b1;
    we_a[TO-1] = 1'b1; ad_a[TO-1] = 16'h00FF;
    do_run(TO);
    check_run("collide", 1'b1, 2'd0, 1'b0, 8'h00, TO);

    // Randomized runs
    dpool[0] = 8'h1F; dpool[1] = 8'h05;
    apool[0] = 16'h0080; apool[1] = 16'h0081; apool[2] = 16'h0082; apool[3] = 16'h0083;
    apool[4] = 16'h00FF;
    for (int r = 0; r < 24; r++) begin
      int mode;
      mode = int'($urandom % 4);
      clear_stim();
      for (int i = 0; i < N; i++) begin
        cha[i] = ($urandom % 8 == 0) ? 16'h00FF : apool[$urandom % 4];
        chd[i] = dpool[$urandom % 2];
      end
      en = 4'($urandom);
      apply_channels(en);
      for (int k = 0; k < MAXC; k++) begin
        we_a[k] = 1'($urandom);
        ad_a[k] = (mode != 0 && $urandom % 24 == 0) ? 16'h00FF : apool[$urandom % 4];
        if ($urandom % 8 == 0) ad_a[k] = 16'($urandom_range(0, 16'h00FE));
        wd_a[k] = ($urandom % 4 == 0) ? 8'($urandom) : dpool[$urandom % 2];
      end
      if (mode == 0) begin
        for (int i = 0; i < N; i++) if (cha[i] == 16'h00FF) cha[i] = 16'h0083;
        apply_channels(en);
      end else begin
        int p;
        p = int'($urandom_range(1, 25));
        we_a[p] = 1'b1; ad_a[p] = 16'h00FF;
      end
      model(en, len, ep, eidx, eto, ebad);
      do_run(len);
      check_run($sformatf("rand%0d", r), ep, eidx, eto, ebad, len);
    end

    // Reset in the middle of a run
    clear_stim();
    @(negedge ph2); start = 1'b1;
    @(negedge ph2); start = 1'b0;
    repeat (5) @(negedge ph2);
    chk("midrun cycles", cycles, 16'd5);
    #2 resetb = 1'b0;
    #1;
    chk("abort done", done, 1'b0);
    chk("abort pass", pass, 1'b0);
    chk("abort fail", fail, 1'b0);
    chk("abort timeout", timeout, 1'b0);
    chk("abort fail_idx", fail_idx, 2'd0);
    chk("abort cycles", cycles, 16'd0);
    chk("abort bad_data", bad_data, 8'h00);
    @(negedge ph2); resetb = 1'b1;
    mem_we = 1'b1; addr = 16'h00FF;
    @(negedge ph2); mem_we = 1'b0; addr = '0;
    repeat (8) @(negedge ph2);
    chk("idle after abort done", done, 1'b0);
    chk("idle after abort cycles", cycles, 16'd0);

    // Recovery run after reset
    clear_stim();
    for (int i = 0; i < N; i++) begin cha[i] = 16'h0080 + 16'(i); chd[i] = 8'h1F; end
    apply_channels(4'b0001);
    we_a[0] = 1'b1; ad_a[0] = 16'h0080; wd_a[0] = 8'h1F;
    we_a[3] = 1'b1; ad_a[3] = 16'h00FF;
    do_run(4);
    check_run("recover", 1'b1, 2'd0, 1'b0, 8'h00, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
